// File: rtl/mk_fifo_ctrl.sv
// Pointer, occupancy and ready bookkeeping for mk_fifo.
// Storage lives in the parent; this block only decides when and where entries move.
module mk_fifo_ctrl #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enq_en,
  input  logic                     deq_en,
  input  logic                     clear,
  output logic                     enq_rdy,
  output logic                     deq_rdy,
  output logic                     enq_fire,
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH)-1:0] tail,
  output logic [CW-1:0]            count
);

  localparam int PW = $clog2(DEPTH);

  logic deq_fire;

  // Readies come only from registered count, so there is no enable-to-ready path.
  assign enq_rdy  = (count != CW'(DEPTH));
  assign deq_rdy  = (count != '0);
  assign enq_fire = enq_en & enq_rdy;
  assign deq_fire = deq_en & deq_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_fire) tail <= tail + PW'(1);
      if (deq_fire) head <= head + PW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mk_fifo.sv
// Small register-based FIFO: unreset per-entry storage indexed by head/tail pointers.
// Reads are combinational from the head entry; no bypass in either direction.
module mk_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             enq_en,
  output logic             enq_rdy,
  input  logic             deq_en,
  output logic             deq_rdy,
  output logic [WIDTH-1:0] deq_data,
  input  logic             clear,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic             enq_fire;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [WIDTH-1:0] mem [DEPTH];

  mk_fifo_ctrl #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq_en   (enq_en),
    .deq_en   (deq_en),
    .clear    (clear),
    .enq_rdy  (enq_rdy),
    .deq_rdy  (deq_rdy),
    .enq_fire (enq_fire),
    .head     (head),
    .tail     (tail),
    .count    (count)
  );

  // Storage is deliberately left out of reset; only the tail-selected entry is written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire && (tail == PW'(i))) mem[i] <= enq_data;
    end
  end

  assign deq_data = mem[head];

endmodule
